// File: rtl/sdr_msoc_cpu_debug_jtag_initiator.sv
// Host-side virtual-JTAG initiator: runs one UIR/CDR/SDR/UDR/RTI sequence per
// command and hands back the TDO bits captured during the DR shift.
module sdr_msoc_cpu_debug_jtag_initiator #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CNT_W  = $clog2(DR_WIDTH + 1);
  localparam int HALF_W = $clog2(TCK_DIV + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DR_WIDTH - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(TCK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SHIFT,
    S_UDR,
    S_RTI,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [HALF_W-1:0]   r_halfCnt;
  logic                r_tckHi;
  logic [CNT_W-1:0]    r_bitCnt;
  logic [IR_WIDTH-1:0] r_cmdIr;
  logic [IR_WIDTH-1:0] r_rspIr;
  logic [DR_WIDTH-1:0] r_cmdDr;
  logic [DR_WIDTH-1:0] r_rspDr;

  logic w_active;
  logic w_periodEnd;
  logic w_sampleTdo;
  logic w_accept;

  assign w_active    = (r_state != S_IDLE) && (r_state != S_RESP);
  assign w_periodEnd = w_active && r_tckHi && (r_halfCnt == HALF_LAST);
  assign w_sampleTdo = (r_state == S_SHIFT) && r_tckHi && (r_halfCnt == '0);
  assign w_accept    = (r_state == S_IDLE) && cmd_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next = S_UIR;
      S_UIR:   if (w_periodEnd) w_next = S_CDR;
      S_CDR:   if (w_periodEnd) w_next = S_SHIFT;
      S_SHIFT: if (w_periodEnd && (r_bitCnt == BIT_LAST)) w_next = S_UDR;
      S_UDR:   if (w_periodEnd) w_next = S_RTI;
      S_RTI:   if (w_periodEnd) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // tck phase counters free-run only while a sequence is active, so every phase
  // starts with tck low and a period always ends on the last tck-high cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_halfCnt <= '0;
      r_tckHi   <= 1'b0;
      r_bitCnt  <= '0;
      r_cmdIr   <= '0;
      r_cmdDr   <= '0;
      r_rspIr   <= '0;
      r_rspDr   <= '0;
    end else begin
      r_state <= w_next;

      if (!w_active) begin
        r_halfCnt <= '0;
        r_tckHi   <= 1'b0;
      end else if (r_halfCnt == HALF_LAST) begin
        r_halfCnt <= '0;
        r_tckHi   <= ~r_tckHi;
      end else begin
        r_halfCnt <= r_halfCnt + 1'b1;
      end

      if (w_accept) begin
        r_cmdIr  <= cmd_ir;
        r_cmdDr  <= cmd_dr;
        r_bitCnt <= '0;
      end else if ((r_state == S_SHIFT) && w_periodEnd) begin
        r_cmdDr  <= r_cmdDr >> 1;
        r_bitCnt <= r_bitCnt + 1'b1;
      end

      if (w_sampleTdo) r_rspDr <= {vji_tdo, r_rspDr[DR_WIDTH-1:1]};
      if ((r_state == S_UIR) && w_periodEnd) r_rspIr <= vji_ir_out;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_dr    = r_rspDr;
  assign rsp_ir    = r_rspIr;
  assign vji_tck   = r_tckHi;
  assign vji_tdi   = (r_state == S_SHIFT) && r_cmdDr[0];
  assign vji_ir_in = w_active ? r_cmdIr : '0;
  assign vji_uir   = (r_state == S_UIR);
  assign vji_cdr   = (r_state == S_CDR);
  assign vji_sdr   = (r_state == S_SHIFT);
  assign vji_udr   = (r_state == S_UDR);
  assign vji_rti   = (r_state == S_RTI);

endmodule

// File: tb/tb_sdr_msoc_cpu_debug_jtag_initiator.sv
// Directed bench for the virtual-JTAG initiator: default build plus a TCK_DIV=1
// build, each exercised through scenario tasks with hand-derived expectations.
module tb_sdr_msoc_cpu_debug_jtag_initiator;

  localparam int DRW = 38;
  localparam int IRW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           cmdValid0 = 1'b0;
  logic           cmdValid1 = 1'b0;
  logic           rspReady = 1'b0;
  logic [IRW-1:0] cmdIr = '0;
  logic [IRW-1:0] irOut = '0;
  logic [DRW-1:0] cmdDr = '0;
  logic           tdo = 1'b0;

  logic           cmdReady0, rspValid0, tck0, tdi0, uir0, cdr0, sdr0, udr0, rti0;
  logic [DRW-1:0] rspDr0;
  logic [IRW-1:0] rspIr0, irIn0;
  logic           cmdReady1, rspValid1, tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;
  logic [DRW-1:0] rspDr1;
  logic [IRW-1:0] rspIr1, irIn1;

  sdr_msoc_cpu_debug_jtag_initiator #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(2)) dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmdValid0), .cmd_ready(cmdReady0), .cmd_ir(cmdIr), .cmd_dr(cmdDr),
    .rsp_valid(rspValid0), .rsp_ready(rspReady), .rsp_dr(rspDr0), .rsp_ir(rspIr0),
    .vji_tck(tck0), .vji_tdi(tdi0), .vji_tdo(tdo), .vji_ir_in(irIn0), .vji_ir_out(irOut),
    .vji_uir(uir0), .vji_cdr(cdr0), .vji_sdr(sdr0), .vji_udr(udr0), .vji_rti(rti0)
  );

  sdr_msoc_cpu_debug_jtag_initiator #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmdValid1), .cmd_ready(cmdReady1), .cmd_ir(cmdIr), .cmd_dr(cmdDr),
    .rsp_valid(rspValid1), .rsp_ready(rspReady), .rsp_dr(rspDr1), .rsp_ir(rspIr1),
    .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo), .vji_ir_in(irIn1), .vji_ir_out(irOut),
    .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1)
  );

  // Observation mux: sel picks which build the scenario is watching.
  bit             sel = 1'b0;
  logic           mReady, mValid, mTck, mTdi;
  logic [DRW-1:0] mDr;
  logic [IRW-1:0] mIr, mIrIn;
  logic [4:0]     mStb;
  logic [8:0]     mVji;

  always_comb begin
    if (sel) begin
      mReady = cmdReady1; mValid = rspValid1; mDr = rspDr1; mIr = rspIr1;
      mTck = tck1; mTdi = tdi1; mIrIn = irIn1; mStb = {uir1, cdr1, sdr1, udr1, rti1};
    end else begin
      mReady = cmdReady0; mValid = rspValid0; mDr = rspDr0; mIr = rspIr0;
      mTck = tck0; mTdi = tdi0; mIrIn = irIn0; mStb = {uir0, cdr0, sdr0, udr0, rti0};
    end
    mVji = {mTck, mTdi, mIrIn, mStb};
  end

  int checks = 0;
  int errors = 0;

  int cyc, latency, overlap, irBad, tdiOnes, tckRises, toggleBad, bitIdx;
  int stbCnt[5];
  int stbFirst[5];
  bit pending, prevTck, prevAct, patMode;
  logic [DRW-1:0] pattern;
  logic [IRW-1:0] expIr;

  task automatic clearMon;
    cyc = 0; latency = 0; overlap = 0; irBad = 0; tdiOnes = 0;
    tckRises = 0; toggleBad = 0; bitIdx = 0;
    pending = 1'b0; prevTck = 1'b0; prevAct = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stbCnt[i] = 0;
      stbFirst[i] = 0;
    end
  endtask

  // Called once per cycle at the falling clk edge; also drives tdo for the next sample.
  task automatic monitorCycle;
    logic [4:0] s;
    s = mStb;
    if ($countones(s) > 1) overlap++;
    for (int i = 0; i < 5; i++) begin
      if (s[i]) begin
        if (stbCnt[i] == 0) stbFirst[i] = cyc;
        stbCnt[i]++;
      end
    end
    if (s != 5'b0) begin
      if (mIrIn !== expIr) irBad++;
    end else if (mIrIn !== '0) begin
      irBad++;
    end
    if (mTdi === 1'b1) tdiOnes++;
    if (prevAct && (s != 5'b0) && (mTck === prevTck)) toggleBad++;
    if (pending) begin
      bitIdx++;
      pending = 1'b0;
    end
    if (s[2] && mTck && !prevTck) begin
      tckRises++;
      pending = 1'b1;
    end
    if (patMode) tdo = (bitIdx < DRW) ? pattern[bitIdx] : 1'b0;
    else tdo = mTdi;
    prevTck = mTck;
    prevAct = (s != 5'b0);
  endtask

  task automatic startCmd(input bit s, input logic [IRW-1:0] ir, input logic [DRW-1:0] dr);
    @(negedge clk);
    sel = s;
    cmdIr = ir;
    cmdDr = dr;
    expIr = ir;
    if (s) cmdValid1 = 1'b1;
    else cmdValid0 = 1'b1;
    #1;
    checks++;
    if (mReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd_ready_before_accept actual=%b required=1", mReady);
    end
    @(posedge clk);
  endtask

  // Starts counting right after the accepting edge, so the first falling edge is cycle 1.
  task automatic runToResp(input bit dropValid);
    clearMon;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (dropValid && (cyc == 1)) begin
        cmdValid0 = 1'b0;
        cmdValid1 = 1'b0;
      end
      monitorCycle;
      if (mValid === 1'b1) break;
      if (cyc >= 2000) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp_timeout actual=%0d cycles required=<2000", cyc);
        break;
      end
    end
    latency = cyc;
  endtask

  task automatic completeRsp;
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0;
    checks++;
    if (mReady !== 1'b1 || mValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_handshake ready/valid actual=%b/%b required=1/0", mReady, mValid);
    end
    checks++;
    if (mVji !== 9'b0) begin
      errors++;
      $display("[TB] FAIL idle_vji actual=%b required=0", mVji);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (cmdReady0 !== 1'b1 || cmdReady1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_cmd_ready actual=%b/%b required=1/1", cmdReady0, cmdReady1);
    end
    checks++;
    if (rspValid0 !== 1'b0 || rspValid1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rsp_valid actual=%b/%b required=0/0", rspValid0, rspValid1);
    end
    checks++;
    if (rspDr0 !== '0 || rspIr0 !== '0) begin
      errors++;
      $display("[TB] FAIL reset_rsp_data actual=%h/%b required=0/0", rspDr0, rspIr0);
    end
    checks++;
    if ({tck0, tdi0, irIn0, uir0, cdr0, sdr0, udr0, rti0} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL reset_vji0 actual=%b required=0",
               {tck0, tdi0, irIn0, uir0, cdr0, sdr0, udr0, rti0});
    end
    checks++;
    if ({tck1, tdi1, irIn1, uir1, cdr1, sdr1, udr1, rti1} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL reset_vji1 actual=%b required=0",
               {tck1, tdi1, irIn1, uir1, cdr1, sdr1, udr1, rti1});
    end
  endtask

  task automatic test_loopback;
    patMode = 1'b0;
    irOut = 2'b00;
    startCmd(1'b0, 2'b01, 38'h2A_5A5A_5A5A);
    runToResp(1'b1);
    checks++;
    if (mDr !== 38'h2A_5A5A_5A5A) begin
      errors++;
      $display("[TB] FAIL loopback_rsp_dr actual=%h required=%h", mDr, 38'h2A_5A5A_5A5A);
    end
    checks++;
    if (latency != 169) begin
      errors++;
      $display("[TB] FAIL loopback_latency actual=%0d required=169", latency);
    end
    checks++;
    if (tckRises != 38) begin
      errors++;
      $display("[TB] FAIL loopback_tck_rises actual=%0d required=38", tckRises);
    end
    checks++;
    if (mIr !== 2'b00) begin
      errors++;
      $display("[TB] FAIL loopback_rsp_ir actual=%b required=00", mIr);
    end
    completeRsp;
  endtask

  task automatic test_pattern;
    patMode = 1'b1;
    pattern = 38'h3F_0000_00FF;
    startCmd(1'b0, 2'b00, 38'h0);
    runToResp(1'b1);
    checks++;
    if (mDr !== 38'h3F_0000_00FF) begin
      errors++;
      $display("[TB] FAIL pattern_rsp_dr actual=%h required=%h", mDr, 38'h3F_0000_00FF);
    end
    checks++;
    if (tdiOnes != 0) begin
      errors++;
      $display("[TB] FAIL pattern_tdi_high_cycles actual=%0d required=0", tdiOnes);
    end
    completeRsp;
    patMode = 1'b0;
  endtask

  task automatic test_strobes;
    int expCnt[5];
    int expFirst[5];
    expCnt   = '{4, 4, 152, 4, 4};
    expFirst = '{165, 161, 9, 5, 1};
    irOut = 2'b10;
    startCmd(1'b0, 2'b11, 38'h15);
    runToResp(1'b1);
    checks++;
    if (mIr !== 2'b10) begin
      errors++;
      $display("[TB] FAIL strobes_rsp_ir actual=%b required=10", mIr);
    end
    checks++;
    if (irBad != 0) begin
      errors++;
      $display("[TB] FAIL strobes_ir_in_bad_cycles actual=%0d required=0", irBad);
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("[TB] FAIL strobes_overlap_cycles actual=%0d required=0", overlap);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (stbCnt[i] != expCnt[i] || stbFirst[i] != expFirst[i]) begin
        errors++;
        $display("[TB] FAIL strobe%0d len/first actual=%0d/%0d required=%0d/%0d",
                 i, stbCnt[i], stbFirst[i], expCnt[i], expFirst[i]);
      end
    end
    checks++;
    if (mDr !== 38'h15) begin
      errors++;
      $display("[TB] FAIL strobes_rsp_dr actual=%h required=%h", mDr, 38'h15);
    end
    completeRsp;
    irOut = 2'b00;
  endtask

  task automatic test_back_to_back;
    int stallBad;
    startCmd(1'b0, 2'b01, 38'h12_3456_789A);
    runToResp(1'b0);
    cmdIr = 2'b10;
    cmdDr = 38'h0A_BCDE_F012;
    stallBad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mDr !== 38'h12_3456_789A || mReady !== 1'b0 || mValid !== 1'b1 || mStb !== 5'b0)
        stallBad++;
    end
    checks++;
    if (stallBad != 0) begin
      errors++;
      $display("[TB] FAIL b2b_stall_bad_cycles actual=%0d required=0", stallBad);
    end
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0;
    checks++;
    if (mReady !== 1'b1 || mValid !== 1'b0 || mStb !== 5'b0) begin
      errors++;
      $display("[TB] FAIL b2b_after_handshake ready/valid/stb actual=%b/%b/%b required=1/0/00000",
               mReady, mValid, mStb);
    end
    expIr = 2'b10;
    @(posedge clk);
    runToResp(1'b1);
    checks++;
    if (stbFirst[4] != 1) begin
      errors++;
      $display("[TB] FAIL b2b_second_uir_start actual=%0d required=1", stbFirst[4]);
    end
    checks++;
    if (latency != 169 || mDr !== 38'h0A_BCDE_F012) begin
      errors++;
      $display("[TB] FAIL b2b_second latency/dr actual=%0d/%h required=169/%h",
               latency, mDr, 38'h0A_BCDE_F012);
    end
    completeRsp;
  endtask

  task automatic test_reset_abort;
    int abortBad;
    startCmd(1'b0, 2'b01, 38'h3_FFFF_FFFF);
    clearMon;
    for (int i = 1; i <= 49; i++) begin
      @(negedge clk);
      cyc = i;
      if (i == 1) cmdValid0 = 1'b0;
      monitorCycle;
    end
    checks++;
    if (mStb !== 5'b00100 || bitIdx != 10) begin
      errors++;
      $display("[TB] FAIL abort_position stb/bit actual=%b/%0d required=00100/10", mStb, bitIdx);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (mVji !== 9'b0 || mReady !== 1'b1 || mValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_reset vji/ready/valid actual=%b/%b/%b required=0/1/0",
               mVji, mReady, mValid);
    end
    abortBad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mValid !== 1'b0 || mVji !== 9'b0) abortBad++;
    end
    checks++;
    if (abortBad != 0) begin
      errors++;
      $display("[TB] FAIL abort_quiet_bad_cycles actual=%0d required=0", abortBad);
    end
    startCmd(1'b0, 2'b01, 38'h2_0000_0001);
    runToResp(1'b1);
    checks++;
    if (latency != 169 || mDr !== 38'h2_0000_0001) begin
      errors++;
      $display("[TB] FAIL abort_recovery latency/dr actual=%0d/%h required=169/%h",
               latency, mDr, 38'h2_0000_0001);
    end
    completeRsp;
  endtask

  task automatic test_tckdiv1;
    startCmd(1'b1, 2'b01, 38'h1);
    runToResp(1'b1);
    checks++;
    if (mDr !== 38'h1) begin
      errors++;
      $display("[TB] FAIL div1_rsp_dr actual=%h required=%h", mDr, 38'h1);
    end
    checks++;
    if (latency != 85) begin
      errors++;
      $display("[TB] FAIL div1_latency actual=%0d required=85", latency);
    end
    checks++;
    if (toggleBad != 0 || tckRises != 38) begin
      errors++;
      $display("[TB] FAIL div1_tck stuck/rises actual=%0d/%0d required=0/38", toggleBad, tckRises);
    end
    completeRsp;
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_pattern;
    test_strobes;
    test_back_to_back;
    test_reset_abort;
    test_tckdiv1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
